// File: rtl/project1_button_debounce_if.sv
// ============================================================================
// Module      : project1_button_debounce_if
// Description : Bundles the raw key pins and the cleaned level/strobe outputs
//               of the push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface project1_button_debounce_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] key_raw;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  // Board / consumer side: drives the pins, observes the cleaned outputs.
  modport master (
    output key_raw,
    input  debounced,
    input  press_pulse,
    input  release_pulse
  );

  // Debouncer side.
  modport slave (
    input  key_raw,
    output debounced,
    output press_pulse,
    output release_pulse
  );
endinterface

`default_nettype wire

// File: rtl/project1_button_debounce.sv
// ============================================================================
// Module      : project1_button_debounce
// Description : Two-flop synchroniser plus per-channel debounce FSM producing
//               an active-high level and one-cycle press/release strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module project1_button_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  project1_button_debounce_if.slave  bus
);

  localparam logic             c_INVERT   = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  logic [WIDTH-1:0] w_key_n;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Normalise so that 1 means pressed; the reset value 0 is then "released".
  assign w_key_n = bus.key_raw ^ {WIDTH{c_INVERT}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_deb;
    logic             w_deb_nxt;
    logic             r_press;
    logic             r_release;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_deb_nxt   = r_deb;
      case (r_state)
        ST_STABLE: begin
          w_cnt_nxt = '0;
          if (r_sync2[i] != r_deb) begin
            w_cnt_nxt   = c_ONE;
            w_state_nxt = ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (r_sync2[i] == r_deb) begin
            // Bounced back before qualifying: drop the partial count.
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == c_TERMINAL) begin
            w_deb_nxt   = r_sync2[i];
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= ST_STABLE;
        r_cnt     <= '0;
        r_deb     <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_deb     <= w_deb_nxt;
        r_press   <= w_deb_nxt & ~r_deb;
        r_release <= ~w_deb_nxt & r_deb;
      end
    end

    assign bus.debounced[i]     = r_deb;
    assign bus.press_pulse[i]   = r_press;
    assign bus.release_pulse[i] = r_release;
  end

endmodule

`default_nettype wire

// File: tb/tb_project1_button_debounce.sv
// ============================================================================
// Module      : tb_project1_button_debounce
// Description : Directed-vector bench for the debouncer, DEBOUNCE_CYCLES=4,
//               with one active-low and one active-high instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_project1_button_debounce;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  project1_button_debounce_if #(.WIDTH(3)) if_a ();
  project1_button_debounce_if #(.WIDTH(3)) if_b ();

  project1_button_debounce #(
    .WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (if_a)
  );

  project1_button_debounce #(
    .WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(0)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs(input bit use_b);
    if (use_b) return {if_b.debounced, if_b.press_pulse, if_b.release_pulse};
    return {if_a.debounced, if_a.press_pulse, if_a.release_pulse};
  endfunction

  // Apply a clean pin level and expect the output to flip on the 6th edge.
  task automatic qualify(input bit use_b, input logic [2:0] key, input logic [2:0] deb_before,
                         input logic [2:0] deb_after, input logic [2:0] press,
                         input logic [2:0] rel, input string tag);
    if (use_b) if_b.key_raw = key;
    else       if_a.key_raw = key;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_val({tag, "_hold"}, 32'(obs(use_b)), 32'({deb_before, 3'b000, 3'b000}));
    end
    tick();
    check_val({tag, "_flip"}, 32'(obs(use_b)), 32'({deb_after, press, rel}));
    tick();
    check_val({tag, "_after"}, 32'(obs(use_b)), 32'({deb_after, 3'b000, 3'b000}));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    if_a.key_raw = 3'b111;
    if_b.key_raw = 3'b000;
    tick();
    tick();
    check_val("reset_a", 32'(obs(1'b0)), 32'd0);
    check_val("reset_b", 32'(obs(1'b1)), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      tick();
      check_val("idle_a", 32'(obs(1'b0)), 32'd0);
      check_val("idle_b", 32'(obs(1'b1)), 32'd0);
    end

    qualify(1'b0, 3'b110, 3'b000, 3'b001, 3'b001, 3'b000, "press0");
    qualify(1'b0, 3'b111, 3'b001, 3'b000, 3'b000, 3'b001, "release0");

    // Bounce on key 1: pressed 3 cycles, released 1, then held pressed.
    if_a.key_raw = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("bounce_a", 32'(obs(1'b0)), 32'd0);
    end
    if_a.key_raw = 3'b111;
    tick();
    check_val("bounce_b", 32'(obs(1'b0)), 32'd0);
    qualify(1'b0, 3'b101, 3'b000, 3'b010, 3'b010, 3'b000, "bounce_press");
    qualify(1'b0, 3'b111, 3'b010, 3'b000, 3'b000, 3'b010, "bounce_release");

    qualify(1'b0, 3'b010, 3'b000, 3'b101, 3'b101, 3'b000, "dual_press");
    qualify(1'b0, 3'b111, 3'b101, 3'b000, 3'b000, 3'b101, "dual_release");

    // Reset in the middle of qualifying key 2 while key 0 is already pressed.
    qualify(1'b0, 3'b110, 3'b000, 3'b001, 3'b001, 3'b000, "pre_reset");
    if_a.key_raw = 3'b010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("mid_qual", 32'(obs(1'b0)), 32'({3'b001, 6'b0}));
    end
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset", 32'(obs(1'b0)), 32'd0);
    tick();
    check_val("in_reset", 32'(obs(1'b0)), 32'd0);
    reset = 1'b0;
    qualify(1'b0, 3'b010, 3'b000, 3'b101, 3'b101, 3'b000, "post_reset");
    qualify(1'b0, 3'b111, 3'b101, 3'b000, 3'b000, 3'b101, "post_reset_rel");

    qualify(1'b1, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000, "hi_press2");
    qualify(1'b1, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100, "hi_release2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
